// File: rtl/xcorr_lag_engine_if.sv
// ---------------------------------------------------------------------------
// xcorr_lag_engine_if
// Sample-in and result-out streams of the cross-correlation engine.
//
// Handshake rule for both streams: a transfer happens on a rising clock edge
// where valid and ready are both high. The producer must not change its data
// or drop valid while valid is high and ready is low. Ready may depend on
// the consumer's state but never on valid.
//
// Signals:
//   in_valid / in_ready / series_x / series_y : sample pair stream (into engine)
//   res_valid / res_ready / result / lag      : per-lag result stream (out)
// Modports:
//   slave  : the engine side
//   master : the source of samples and the sink of results
// ---------------------------------------------------------------------------
interface xcorr_lag_engine_if #(
  parameter int DATAWIDTH = 24,
  parameter int LAG_WIDTH = 12,
  parameter int ACC_WIDTH = 58
);
  logic                        in_valid;
  logic                        in_ready;
  logic signed [DATAWIDTH-1:0] series_x;
  logic signed [DATAWIDTH-1:0] series_y;
  logic                        res_valid;
  logic                        res_ready;
  logic signed [ACC_WIDTH-1:0] result;
  logic signed [LAG_WIDTH-1:0] lag;

  modport slave (
    input  in_valid, series_x, series_y, res_ready,
    output in_ready, res_valid, result, lag
  );

  modport master (
    output in_valid, series_x, series_y, res_ready,
    input  in_ready, res_valid, result, lag
  );
endinterface

// File: rtl/xcorr_lag_engine.sv
// ---------------------------------------------------------------------------
// xcorr_lag_engine
// Buffers SEQUENCE_LENGTH (x, y) sample pairs, then computes
//   R[k] = sum_n x[n+k] * y[n]   for k = -MAX_LAG .. +MAX_LAG
// one multiply-accumulate per clock, streams every (lag, R) pair out and
// publishes the lag of the largest R once the frame is finished.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus (slave)  : sample input stream and result output stream
//   complete     : one-cycle pulse when a frame has finished
//   peak_lag     : lag of the peak R of the last completed frame
//   peak_value   : R at peak_lag (signed)
//   busy         : high while computing / outputting / finishing a frame
//   dbg_state    : current FSM state (FILL=0, CALC=1, OUT=2, DONE=3)
//
// Build option: define XCORR_ABS_PEAK_EN to pick the peak by |R| instead of
// by signed R. The result stream is the same in both builds.
// ---------------------------------------------------------------------------
module xcorr_lag_engine #(
  parameter int DATAWIDTH       = 24,
  parameter int SEQUENCE_LENGTH = 512,
  parameter int ADDR_WIDTH      = 9,
  parameter int MAX_LAG         = 16,
  parameter int LAG_WIDTH       = 12,
  parameter int ACC_WIDTH       = 2*DATAWIDTH+ADDR_WIDTH+1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  xcorr_lag_engine_if.slave           bus,
  output logic                        complete,
  output logic signed [LAG_WIDTH-1:0] peak_lag,
  output logic signed [ACC_WIDTH-1:0] peak_value,
  output logic                        busy,
  output logic [1:0]                  dbg_state
);
  localparam logic [1:0] S_FILL = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int CW = ADDR_WIDTH + 1;   // term/cycle counter must reach N+1
  localparam int PW = 2 * DATAWIDTH;    // full product width

  localparam logic signed [LAG_WIDTH-1:0] K_MIN    = LAG_WIDTH'(-MAX_LAG);
  localparam logic signed [LAG_WIDTH-1:0] K_MAX    = LAG_WIDTH'(MAX_LAG);
  localparam logic [CW-1:0]               N_CW     = CW'(SEQUENCE_LENGTH);
  localparam logic [ADDR_WIDTH-1:0]       CNT_LAST = ADDR_WIDTH'(SEQUENCE_LENGTH - 1);

  // Sample buffers: written only in FILL, read only in CALC.
  logic signed [DATAWIDTH-1:0] x_mem [SEQUENCE_LENGTH];
  logic signed [DATAWIDTH-1:0] y_mem [SEQUENCE_LENGTH];
  logic signed [DATAWIDTH-1:0] rd_x_q, rd_y_q;

  logic [1:0]                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]       cnt_q, cnt_d;
  logic signed [LAG_WIDTH-1:0] k_q, k_d;
  logic [CW-1:0]               idx_q, idx_d;
  logic                        rd_vld_q, rd_vld_d;
  logic                        prod_vld_q, prod_vld_d;
  logic signed [PW-1:0]        prod_q, prod_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0] run_val_q, run_val_d;
  logic signed [LAG_WIDTH-1:0] run_lag_q, run_lag_d;
  logic signed [ACC_WIDTH-1:0] peak_val_q, peak_val_d;
  logic signed [LAG_WIDTH-1:0] peak_lag_q, peak_lag_d;

  logic [LAG_WIDTH-1:0]  k_abs;
  logic [CW-1:0]         terms;
  logic [ADDR_WIDTH-1:0] x_addr, y_addr;
  logic                  wr_en, rd_en, better;

  function automatic logic [ACC_WIDTH-1:0] mag(input logic signed [ACC_WIDTH-1:0] v);
    return v[ACC_WIDTH-1] ? ACC_WIDTH'(-v) : ACC_WIDTH'(v);
  endfunction

  // For lag k only n in [max(0,-k), min(N-1,N-1-k)] contributes: N-|k| terms.
  // Term number idx reads x[idx+max(k,0)] and y[idx+max(-k,0)].
  always_comb begin
    k_abs  = k_q[LAG_WIDTH-1] ? LAG_WIDTH'(-k_q) : LAG_WIDTH'(k_q);
    terms  = N_CW - CW'(k_abs);
    x_addr = ADDR_WIDTH'(idx_q) + (k_q[LAG_WIDTH-1] ? '0 : ADDR_WIDTH'(k_abs));
    y_addr = ADDR_WIDTH'(idx_q) + (k_q[LAG_WIDTH-1] ? ADDR_WIDTH'(k_abs) : '0);
    wr_en  = (state_q == S_FILL) && bus.in_valid;
    rd_en  = (state_q == S_CALC) && (idx_q < terms);
  end

`ifdef XCORR_ABS_PEAK_EN
  assign better = mag(acc_q) > mag(run_val_q);
`else
  assign better = acc_q > run_val_q;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    k_d        = k_q;
    idx_d      = idx_q;
    run_val_d  = run_val_q;
    run_lag_d  = run_lag_q;
    peak_val_d = peak_val_q;
    peak_lag_d = peak_lag_q;
    // Pipeline: read issued -> data registered -> product registered -> add.
    rd_vld_d   = rd_en;
    prod_vld_d = rd_vld_q;
    prod_d     = PW'(rd_x_q) * PW'(rd_y_q);
    acc_d      = acc_q;
    if (prod_vld_q) begin
      acc_d = acc_q + {{(ACC_WIDTH-PW){prod_q[PW-1]}}, prod_q};
    end

    case (state_q)
      S_FILL: begin
        if (bus.in_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = S_CALC;
            k_d     = K_MIN;
            idx_d   = '0;
            acc_d   = '0;
          end
        end
      end
      S_CALC: begin
        // Last term lands in the accumulator two cycles after its read.
        if (idx_q == terms + 1'b1) begin
          state_d = S_OUT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_OUT: begin
        if (bus.res_ready) begin
          // Strict compare: ties keep the earlier (more negative) lag.
          if ((k_q == K_MIN) || better) begin
            run_val_d = acc_q;
            run_lag_d = k_q;
          end
          if (k_q < K_MAX) begin
            k_d     = k_q + LAG_WIDTH'(1);
            idx_d   = '0;
            acc_d   = '0;
            state_d = S_CALC;
          end else begin
            // Publish together with the DONE cycle so peak is valid at complete.
            peak_val_d = run_val_d;
            peak_lag_d = run_lag_d;
            state_d    = S_DONE;
          end
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_FILL;
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      x_mem[cnt_q] <= bus.series_x;
      y_mem[cnt_q] <= bus.series_y;
    end
    if (rd_en) begin
      rd_x_q <= x_mem[x_addr];
      rd_y_q <= y_mem[y_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FILL;
      cnt_q      <= '0;
      k_q        <= '0;
      idx_q      <= '0;
      rd_vld_q   <= 1'b0;
      prod_vld_q <= 1'b0;
      prod_q     <= '0;
      acc_q      <= '0;
      run_val_q  <= '0;
      run_lag_q  <= '0;
      peak_val_q <= '0;
      peak_lag_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      idx_q      <= idx_d;
      rd_vld_q   <= rd_vld_d;
      prod_vld_q <= prod_vld_d;
      prod_q     <= prod_d;
      acc_q      <= acc_d;
      run_val_q  <= run_val_d;
      run_lag_q  <= run_lag_d;
      peak_val_q <= peak_val_d;
      peak_lag_q <= peak_lag_d;
    end
  end

  // The accumulator only changes in CALC, so result is stable throughout OUT.
  assign bus.in_ready  = (state_q == S_FILL);
  assign bus.res_valid = (state_q == S_OUT);
  assign bus.result    = acc_q;
  assign bus.lag       = k_q;
  assign complete      = (state_q == S_DONE);
  assign busy          = (state_q != S_FILL);
  assign peak_lag      = peak_lag_q;
  assign peak_value    = peak_val_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_xcorr_lag_engine.sv
// ---------------------------------------------------------------------------
// tb_xcorr_lag_engine
// Bench for xcorr_lag_engine with N=8, MAX_LAG=2, DATAWIDTH=24.
// Reference: direct evaluation of R[k] = sum_n x[n+k]*y[n] over the buffered
// frame plus a linear peak search; expected results go into a queue that the
// result stream is drained against.
// ---------------------------------------------------------------------------
module tb_xcorr_lag_engine;
  localparam int DW    = 24;
  localparam int N     = 8;
  localparam int AW    = 3;
  localparam int M     = 2;
  localparam int LW    = 12;
  localparam int ACC_W = 2*DW + AW + 1;
  localparam int NLAG  = 2*M + 1;
  localparam int BUDGET = 4000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xcorr_lag_engine_if #(.DATAWIDTH(DW), .LAG_WIDTH(LW), .ACC_WIDTH(ACC_W)) bus ();

  logic                    complete, busy;
  logic signed [LW-1:0]    peak_lag;
  logic signed [ACC_W-1:0] peak_value;
  logic [1:0]              dbg_state;

  xcorr_lag_engine #(
    .DATAWIDTH(DW), .SEQUENCE_LENGTH(N), .ADDR_WIDTH(AW),
    .MAX_LAG(M), .LAG_WIDTH(LW), .ACC_WIDTH(ACC_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .complete(complete), .peak_lag(peak_lag), .peak_value(peak_value),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int check_cnt = 0;
  int pass_cnt  = 0;
  logic [ACC_W-1:0] exp_q[$];
  logic [LW-1:0]    exp_lag_q[$];
  logic [ACC_W-1:0] exp_peak_val;
  logic [LW-1:0]    exp_peak_lag;
  logic signed [DW-1:0] fx [N];
  logic signed [DW-1:0] fy [N];

  function automatic logic [63:0] zacc(input logic [ACC_W-1:0] v);
    return 64'(v);
  endfunction

  function automatic logic [63:0] zlag(input logic [LW-1:0] v);
    return 64'(v);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic longint labs(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic bit beats(input longint r, input longint best);
`ifdef XCORR_ABS_PEAK_EN
    return labs(r) > labs(best);
`else
    return r > best;
`endif
  endfunction

  // Reference model: correlation by definition and a first-wins peak search.
  task automatic load_expect();
    longint r, best_r;
    int best_k;
    best_r = 0;
    best_k = -M;
    for (int k = -M; k <= M; k++) begin
      r = 0;
      for (int n = 0; n < N; n++) begin
        if (n + k >= 0 && n + k < N) r += longint'(fx[n+k]) * longint'(fy[n]);
      end
      exp_q.push_back(ACC_W'(r));
      exp_lag_q.push_back(LW'(k));
      if (k == -M || beats(r, best_r)) begin
        best_r = r;
        best_k = k;
      end
    end
    exp_peak_val = ACC_W'(best_r);
    exp_peak_lag = LW'(best_k);
  endtask

  task automatic rand_frame();
    for (int i = 0; i < N; i++) begin
      fx[i] = DW'($urandom);
      fy[i] = DW'($urandom);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic fill_frame(input int gap);
    for (int i = 0; i < N; i++) begin
      for (int g = 0; g < gap; g++) begin
        bus.in_valid = 1'b0;
        bus.series_x = DW'($urandom);
        bus.series_y = DW'($urandom);
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.series_x = fx[i];
      bus.series_y = fy[i];
      check("in_ready_fill", 64'(bus.in_ready), 64'd1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  // Drains the result stream. in_valid is toggled with junk data throughout,
  // which the engine must ignore outside FILL.
  task automatic collect(input bit stall, input bit rnd_ready);
    int got, comps, cyc, hold;
    bit have_hold;
    logic [ACC_W-1:0] held_r, er;
    logic [LW-1:0]    held_l, el;
    got = 0; comps = 0; cyc = 0; hold = 0; have_hold = 1'b0;
    held_r = '0; held_l = '0;
    while ((got < NLAG || comps == 0) && cyc < BUDGET) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.series_x = DW'($urandom);
      bus.series_y = DW'($urandom);
      if (complete) begin
        comps++;
        check("peak_lag", zlag(peak_lag), zlag(exp_peak_lag));
        check("peak_value", zacc(peak_value), zacc(exp_peak_val));
        check("complete_after_all_results", 64'(got), 64'(NLAG));
        bus.in_valid = 1'b0;
      end
      if (bus.res_valid) begin
        check("in_ready_low_in_out", 64'(bus.in_ready), 64'd0);
        if (!have_hold) begin
          held_r = bus.result;
          held_l = bus.lag;
          have_hold = 1'b1;
          hold = 0;
        end else begin
          check("stall_result_stable", zacc(bus.result), zacc(held_r));
          check("stall_lag_stable", zlag(bus.lag), zlag(held_l));
        end
        if (stall && hold < 20) begin
          bus.res_ready = 1'b0;
          hold++;
        end else begin
          bus.res_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (bus.res_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", 64'd1, 64'd0);
          end else begin
            er = exp_q.pop_front();
            el = exp_lag_q.pop_front();
            check("result", zacc(bus.result), zacc(er));
            check("lag", zlag(bus.lag), zlag(el));
          end
          got++;
          have_hold = 1'b0;
        end
      end else begin
        bus.res_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.res_ready = 1'b0;
    check("results_delivered", 64'(got), 64'(NLAG));
    check("complete_pulses", 64'(comps), 64'd1);
    check("complete_one_cycle", 64'(complete), 64'd0);
    check("in_ready_after_done", 64'(bus.in_ready), 64'd1);
    check("busy_after_done", 64'(busy), 64'd0);
  endtask

  task automatic run_frame(input int gap, input bit stall, input bit rnd_ready);
    load_expect();
    fill_frame(gap);
    collect(stall, rnd_ready);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("rst_result", zacc(bus.result), 64'd0);
    check("rst_lag", zlag(bus.lag), 64'd0);
    check("rst_complete", 64'(complete), 64'd0);
    check("rst_peak_lag", zlag(peak_lag), 64'd0);
    check("rst_peak_value", zacc(peak_value), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int cyc, comps;
    bus.in_valid  = 1'b0;
    bus.series_x  = '0;
    bus.series_y  = '0;
    bus.res_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Impulse: x[3]=1, y[1]=1 -> only R[2]=1.
    for (int i = 0; i < N; i++) begin fx[i] = '0; fy[i] = '0; end
    fx[3] = 1; fy[1] = 1;
    run_frame(0, 1'b0, 1'b0);

    // Full-scale negative samples: largest products, no overflow.
    for (int i = 0; i < N; i++) begin fx[i] = -24'sd8388608; fy[i] = -24'sd8388608; end
    run_frame(0, 1'b0, 1'b1);

    // Negative peak at lag 0.
    for (int i = 0; i < N; i++) begin fx[i] = '0; fy[i] = '0; end
    fx[2] = -5; fy[2] = 1;
    run_frame(0, 1'b0, 1'b0);

    // Backpressure: 20 stalled cycles on every lag, random data.
    rand_frame();
    run_frame(0, 1'b1, 1'b0);

    // Reset during lag 0 of a random frame.
    rand_frame();
    fill_frame(0);
    bus.res_ready = 1'b1;
    cyc = 0; comps = 0;
    while (!(busy && !bus.res_valid && bus.lag == 0) && cyc < BUDGET) begin
      if (complete) comps++;
      @(posedge clk); #1;
      cyc++;
    end
    check("reached_lag0_calc", 64'(cyc < BUDGET), 64'd1);
    repeat (3) begin
      if (complete) comps++;
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("no_complete_before_abort", 64'(comps), 64'd0);
    check_reset_outputs();
    bus.res_ready = 1'b0;
    @(posedge clk); #1;
    check("abort_no_complete", 64'(complete), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    rand_frame();
    run_frame(0, 1'b0, 1'b1);

    // Back-to-back frames with a pair offered only every third cycle.
    rand_frame();
    run_frame(2, 1'b0, 1'b1);
    rand_frame();
    run_frame(2, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
